alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage_if.sv | 29 ++
 rtl/alu_operand_stage.sv | 103 ++++++++++
 tb/tb_alu_operand_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus between the upstream issue logic, the operand stage and the ALU.
// The slave view belongs to the stage; the master view belongs to whatever drives it.
interface alu_operand_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_opcode;
   logic [4:0]       in_shamt;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_opcode;
   logic [4:0]       out_shamt;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic             out_illegal;

   modport slave (
      input  in_valid, in_opcode, in_shamt, in_a, in_b, out_ready,
      output in_ready, out_valid, out_opcode, out_shamt, out_a, out_b, out_illegal
   );

   modport master (
      output in_valid, in_opcode, in_shamt, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_opcode, out_shamt, out_a, out_b, out_illegal
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Two-entry in-order skid buffer in front of the ALU, with a registered in_ready,
// an illegal-opcode flag on the presented operation and a wrapping issue counter.
module alu_operand_stage #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 flush,
   alu_operand_stage_if.slave   bus,
   output logic [CNTW-1:0]      issue_count
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   typedef struct packed {
      logic [4:0]       opcode;
      logic [4:0]       shamt;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } op_t;

   state_t          state_q, state_d;
   logic            in_ready_q;
   op_t             main_q, main_d;
   op_t             skid_q, skid_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   op_t             in_op;
   logic            out_valid;
   logic            in_xfer;
   logic            out_xfer;

   assign in_op = {bus.in_opcode, bus.in_shamt, bus.in_a, bus.in_b};

   // in_ready is computed from the next state so it never depends on out_ready combinationally.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (in_xfer) state_d = ONE;
         ONE: begin
            if (in_xfer && !out_xfer)      state_d = FULL;
            else if (!in_xfer && out_xfer) state_d = EMPTY;
         end
         FULL:    if (out_xfer) state_d = ONE;
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   always_comb begin
      out_valid = (state_q == ONE) || (state_q == FULL);
      in_xfer   = bus.in_valid && in_ready_q;
      out_xfer  = out_valid && bus.out_ready;
   end

   // Data moves regardless of flush; flush only clears the occupancy state.
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      case (state_q)
         EMPTY: if (in_xfer) main_d = in_op;
         ONE: begin
            if (in_xfer && out_xfer) main_d = in_op;
            else if (in_xfer)        skid_d = in_op;
         end
         FULL:    if (out_xfer) main_d = skid_q;
         default: ;
      endcase
      cnt_d = out_xfer ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         main_q <= '0;
         skid_q <= '0;
         cnt_q  <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid;
   assign bus.out_opcode  = main_q.opcode;
   assign bus.out_shamt   = main_q.shamt;
   assign bus.out_a       = main_q.a;
   assign bus.out_b       = main_q.b;
   assign bus.out_illegal = out_valid && (main_q.opcode > 5'b00101);
   assign issue_count     = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed operations go into an expectation queue,
// a negedge monitor pops and compares every output transfer and the issue count.
module tb_alu_operand_stage;

   localparam int WIDTH = 32;
   localparam int CNTW  = 4;

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      logic        ill;
   } exp_t;

   logic            clock;
   logic            resetn;
   logic            flush;
   logic [CNTW-1:0] issue_count;
   logic [CNTW-1:0] exp_cnt;
   exp_t            sbq[$];
   int              nvec;
   int              nerr;

   alu_operand_stage_if #(.WIDTH(WIDTH)) bus ();

   alu_operand_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .flush      (flush),
      .bus        (bus),
      .issue_count(issue_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every output transfer must match the oldest accepted operation.
   always @(negedge clock) begin
      if (resetn && bus.out_valid && bus.out_ready) begin
         if (sbq.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL out_unexpected: got opcode %0h a %0h with empty scoreboard",
                     bus.out_opcode, bus.out_a);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("out_opcode", bus.out_opcode, e.op);
            chk("out_shamt", bus.out_shamt, e.sh);
            chk("out_a", bus.out_a, e.a);
            chk("out_b", bus.out_b, e.b);
            chk("out_illegal", bus.out_illegal, e.ill);
            chk("issue_count_pre", issue_count, exp_cnt);
         end
         exp_cnt = exp_cnt + 1'b1;
      end
   end

   task automatic send(input logic [4:0] op, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic ill);
      int   n;
      exp_t e;
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_shamt  = sh;
      bus.in_a      = a;
      bus.in_b      = b;
      n = 0;
      @(negedge clock);
      while (!bus.in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!bus.in_ready) begin
         nvec++;
         nerr++;
         $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
      end else begin
         e.op = op; e.sh = sh; e.a = a; e.b = b; e.ill = ill;
         sbq.push_back(e);
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(posedge clock);
         n++;
      end
      #1;
      chk("drain_left", sbq.size(), 0);
   endtask

   initial begin
      nvec          = 0;
      nerr          = 0;
      exp_cnt       = '0;
      resetn        = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_shamt  = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_issue_count", issue_count, 0);
      chk("rst_out_a", bus.out_a, 0);
      chk("rst_out_opcode", bus.out_opcode, 0);
      #1 resetn = 1'b1;
      #1 chk("in_ready_before_edge", bus.in_ready, 0);
      @(posedge clock);
      #1 chk("in_ready_after_edge", bus.in_ready, 1);

      // Stream
      bus.out_ready = 1'b1;
      send(5'b00011, 5'd0, 32'd188899668, 32'd1, 1'b0);
      drain();
      chk("stream_count", issue_count, 1);

      // Backpressure: A then B, A held stable
      bus.out_ready = 1'b0;
      send(5'b00000, 5'd3, 32'h1111_0000, 32'd5, 1'b0);
      send(5'b00001, 5'd7, 32'hAAAA_5555, 32'hFFFF_FFFF, 1'b0);
      chk("bp_in_ready_full", bus.in_ready, 0);
      chk("bp_hold_a", bus.out_a, 32'h1111_0000);
      repeat (2) @(posedge clock);
      #1;
      chk("bp_hold_a_later", bus.out_a, 32'h1111_0000);
      chk("bp_hold_op", bus.out_opcode, 5'b00000);
      chk("bp_hold_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      drain();
      chk("bp_in_ready_back", bus.in_ready, 1);
      chk("bp_count", issue_count, 3);

      // Illegal opcodes transfer like legal ones
      send(5'b00110, 5'd1, 32'hDEAD_BEEF, 32'h0000_0002, 1'b1);
      send(5'b11111, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b1);
      send(5'b00101, 5'd4, 32'h8000_0000, 32'h0000_0000, 1'b0);
      drain();
      chk("ill_count", issue_count, 6);

      // Flush from FULL with out_ready high
      bus.out_ready = 1'b0;
      send(5'b00010, 5'd0, 32'hC0C0_C0C0, 32'h0F0F_0F0F, 1'b0);
      send(5'b00100, 5'd9, 32'hD0D0_D0D0, 32'h1234_5678, 1'b0);
      chk("fl_full_valid", bus.out_valid, 1);
      chk("fl_full_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      flush         = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      sbq.delete();
      chk("fl_out_valid", bus.out_valid, 0);
      chk("fl_in_ready", bus.in_ready, 1);
      chk("fl_count", issue_count, 7);
      send(5'b00001, 5'd2, 32'h0000_0064, 32'h0000_0032, 1'b0);
      drain();
      chk("post_flush_count", issue_count, 8);

      // Async reset while FULL
      bus.out_ready = 1'b0;
      send(5'b00000, 5'd5, 32'h5555_AAAA, 32'h7777_7777, 1'b0);
      send(5'b00011, 5'd6, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
      #3 resetn = 1'b0;
      #1;
      chk("ar_out_valid", bus.out_valid, 0);
      chk("ar_in_ready", bus.in_ready, 0);
      chk("ar_out_a", bus.out_a, 0);
      chk("ar_out_b", bus.out_b, 0);
      chk("ar_out_opcode", bus.out_opcode, 0);
      chk("ar_out_shamt", bus.out_shamt, 0);
      chk("ar_count", issue_count, 0);
      sbq.delete();
      exp_cnt = '0;
      @(negedge clock);
      #2 resetn = 1'b1;
      @(posedge clock);
      #1;
      chk("ar_in_ready_up", bus.in_ready, 1);
      chk("ar_valid_after", bus.out_valid, 0);

      // Counter wrap: 17 transfers on a 4-bit counter
      bus.out_ready = 1'b1;
      for (int i = 0; i < 17; i++)
         send(5'(i % 6), 5'(i), 32'(i * 3 + 1), 32'(32'hFFFF_FFFF - i), 1'b0);
      drain();
      chk("wrap_count", issue_count, 1);
      chk("final_sb_empty", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
